// File: rtl/beta_mc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the Beta datapath.
// Interrupts are taken only after WB; memory stalls past TIMEOUT trap to ILLOP.
module beta_mc_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic        cu_moe,
    input  logic        cu_mwr,
    input  logic        cu_werf,
    input  logic [2:0]  cu_pcsel,
    output logic        imem_req,
    output logic [31:0] ir,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_en,
    output logic [2:0]  pcsel,
    output logic        wasel_xp,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_IRQ   = 3'd5;
    localparam logic [2:0] S_TRAP  = 3'd6;

    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);
    localparam bit            TIMEOUT_ON  = (TIMEOUT != 0);

    logic [2:0]    state_reg, state_next;
    logic [31:0]   ir_reg;
    logic [TW-1:0] wait_reg;
    logic          bus_err_reg;
    logic          timed_out;

    // Ack has priority over the timeout, so a same-cycle ack completes normally.
    assign timed_out = TIMEOUT_ON && (wait_reg == TIMEOUT_CNT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack)       state_next = S_EXEC;
                else if (timed_out) state_next = S_TRAP;
            end
            S_EXEC:  state_next = (cu_moe || cu_mwr) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)       state_next = S_WB;
                else if (timed_out) state_next = S_TRAP;
            end
            S_WB:    state_next = irq ? S_IRQ : S_FETCH;
            S_IRQ:   state_next = S_FETCH;
            S_TRAP:  state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ir_reg      <= '0;
            wait_reg    <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH && imem_ack)
                ir_reg <= imem_rdata;
            // Any state change restarts the count; this covers every entry to FETCH/MEM.
            if (state_next != state_reg)
                wait_reg <= '0;
            else if ((state_reg == S_FETCH || state_reg == S_MEM) && wait_reg != {TW{1'b1}})
                wait_reg <= wait_reg + 1'b1;
            if (state_reg == S_TRAP)
                bus_err_reg <= 1'b1;
        end
    end

    always_comb begin
        imem_req = (state_reg == S_FETCH);
        dmem_req = (state_reg == S_MEM);
        dmem_we  = (state_reg == S_MEM) && cu_mwr;
        rf_we    = ((state_reg == S_WB) && cu_werf) || (state_reg == S_IRQ) || (state_reg == S_TRAP);
        pc_en    = (state_reg == S_WB) || (state_reg == S_IRQ) || (state_reg == S_TRAP);
        wasel_xp = (state_reg == S_IRQ) || (state_reg == S_TRAP);
        case (state_reg)
            S_WB:    pcsel = cu_pcsel;
            S_IRQ:   pcsel = 3'b100;
            S_TRAP:  pcsel = 3'b011;
            default: pcsel = 3'b000;
        endcase
    end

    assign ir      = ir_reg;
    assign bus_err = bus_err_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_beta_mc_sequencer.sv
// Directed bench for beta_mc_sequencer: ALU, LD, ST, fetch timeout, irq, async reset.
module tb_beta_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_ack;
    logic        cu_moe;
    logic        cu_mwr;
    logic        cu_werf;
    logic [2:0]  cu_pcsel;
    logic        imem_req;
    logic [31:0] ir;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_en;
    logic [2:0]  pcsel;
    logic        wasel_xp;
    logic        bus_err;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    beta_mc_sequencer #(.TIMEOUT(15), .TW(4)) dut (
        .clk(clk), .reset(reset), .irq(irq),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dmem_ack(dmem_ack),
        .cu_moe(cu_moe), .cu_mwr(cu_mwr), .cu_werf(cu_werf), .cu_pcsel(cu_pcsel),
        .imem_req(imem_req), .ir(ir), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_en(pc_en), .pcsel(pcsel), .wasel_xp(wasel_xp),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; irq = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; cu_moe = 1'b0; cu_mwr = 1'b0; cu_werf = 1'b0; cu_pcsel = 3'd0;
        tick(); tick();
        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", ir, 32'h0);
        check("rst_outs", {imem_req, dmem_req, dmem_we, rf_we, pc_en, wasel_xp, bus_err, pcsel},
              32'h0);

        // 1: ALU with imem_ack on the third FETCH cycle
        reset = 1'b0; cu_werf = 1'b1; cu_pcsel = 3'd0; imem_rdata = 32'h8000_0000;
        tick(); check("t1_s1", 32'(state), 32'd1);
        check("t1_imem_req", 32'(imem_req), 32'd1);
        tick(); check("t1_s2", 32'(state), 32'd1);
        tick(); check("t1_s3", 32'(state), 32'd1);
        imem_ack = 1'b1;
        tick(); check("t1_exec", 32'(state), 32'd2);
        check("t1_ir", ir, 32'h8000_0000);
        check("t1_exec_pc_en", 32'(pc_en), 32'd0);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        tick(); check("t1_wb", 32'(state), 32'd4);
        check("t1_wb_outs", {rf_we, pc_en, pcsel}, {2'b11, 3'b000});
        tick(); check("t1_fetch", 32'(state), 32'd1);
        check("t1_after_outs", {rf_we, pc_en}, 32'd0);
        check("t1_ir_hold", ir, 32'h8000_0000);

        // 2: LD, dmem_ack three cycles after MEM entry
        imem_ack = 1'b1; imem_rdata = 32'h6000_0004; cu_moe = 1'b1; cu_werf = 1'b1;
        tick(); check("t2_exec", 32'(state), 32'd2);
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_mem_state", 32'(state), 32'd3);
            check("t2_mem_req_we", {dmem_req, dmem_we}, 32'b10);
            if (i == 3) dmem_ack = 1'b1;
        end
        tick(); check("t2_wb", 32'(state), 32'd4);
        check("t2_wb_rf_we", 32'(rf_we), 32'd1);
        check("t2_wb_dmem_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0; cu_moe = 1'b0;
        tick(); check("t2_fetch", 32'(state), 32'd1);

        // 3: ST with ack on the first MEM cycle
        imem_ack = 1'b1; imem_rdata = 32'h6400_0008; cu_mwr = 1'b1; cu_werf = 1'b0;
        tick(); check("t3_exec", 32'(state), 32'd2);
        imem_ack = 1'b0;
        tick(); check("t3_mem", 32'(state), 32'd3);
        check("t3_mem_req_we", {dmem_req, dmem_we}, 32'b11);
        dmem_ack = 1'b1;
        tick(); check("t3_wb", 32'(state), 32'd4);
        check("t3_wb_outs", {rf_we, pc_en, dmem_we}, 32'b010);
        dmem_ack = 1'b0; cu_mwr = 1'b0;
        tick(); check("t3_fetch", 32'(state), 32'd1);

        // 4: fetch timeout -> 16 FETCH cycles then TRAP
        for (int i = 0; i < 16; i++) begin
            check("t4_fetch_wait", 32'(state), 32'd1);
            tick();
        end
        check("t4_trap", 32'(state), 32'd6);
        check("t4_trap_outs", {rf_we, pc_en, wasel_xp, pcsel}, {3'b111, 3'b011});
        tick(); check("t4_fetch", 32'(state), 32'd1);
        check("t4_bus_err", 32'(bus_err), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h8020_0000; cu_werf = 1'b1; cu_pcsel = 3'd2;
        tick(); imem_ack = 1'b0;
        check("t4_exec", 32'(state), 32'd2);
        tick(); check("t4_wb_pcsel", 32'(pcsel), 32'd2);
        check("t4_bus_err_hold", 32'(bus_err), 32'd1);

        // 5: irq held from FETCH through WB
        tick(); check("t5_fetch", 32'(state), 32'd1);
        irq = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8040_0000;
        tick(); check("t5_exec", 32'(state), 32'd2);
        imem_ack = 1'b0;
        tick(); check("t5_wb", 32'(state), 32'd4);
        check("t5_wb_xp", {wasel_xp, pcsel}, {1'b0, 3'd2});
        tick(); check("t5_irq", 32'(state), 32'd5);
        check("t5_irq_outs", {rf_we, pc_en, wasel_xp, pcsel}, {3'b111, 3'b100});
        irq = 1'b0;
        tick(); check("t5_fetch2", 32'(state), 32'd1);

        // 6: async reset during MEM, then a stray dmem_ack
        imem_ack = 1'b1; imem_rdata = 32'h6000_0010; cu_moe = 1'b1;
        tick(); imem_ack = 1'b0;
        tick(); check("t6_mem", 32'(state), 32'd3);
        check("t6_mem_req", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("t6_rst_ir", ir, 32'h0);
        check("t6_rst_bus_err", 32'(bus_err), 32'd0);
        dmem_ack = 1'b1; cu_moe = 1'b0;
        tick(); reset = 1'b0;
        tick(); check("t6_fetch", 32'(state), 32'd1);
        tick(); check("t6_stray_ack", 32'(state), 32'd1);
        check("t6_no_dmem_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
